// File: rtl/boot_loader.sv
// Boot stage: receives a length-prefixed, XOR-checksummed byte image, writes big-endian
// words into instruction memory from address 0, and releases the core only after a good checksum.
module boot_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  restart,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]           imem_wdata,
   output logic                  imem_wena,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      HDR_HI  = 3'd0,
      HDR_LO  = 3'd1,
      PAYLOAD = 3'd2,
      CSUM    = 3'd3,
      RUN     = 3'd4,
      ERROR   = 3'd5
   } state_t;

   // Compared in 17 bits so a full 16-bit length cannot alias the limit.
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t                  state_q;
   logic [15:0]             len_q;
   logic [1:0]              byte_cnt_q;
   logic [15:0]             word_cnt_q;
   logic [7:0]              acc_q;
   logic [23:0]             asm_q;
   logic [ADDR_WIDTH-1:0]   waddr_q;
   logic [31:0]             wdata_q;
   logic                    wena_q;
   logic                    cpu_reset_q;
   logic                    done_q;
   logic                    error_q;

   logic                    xfer_s;
   logic [15:0]             len_d;
   logic [31:0]             word_d;
   logic [7:0]              acc_d;
   logic                    last_word_s;

   // Byte acceptance is a pure decode of the loading states.
   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         HDR_HI, HDR_LO, PAYLOAD, CSUM: rx_ready = 1'b1;
         default:                       rx_ready = 1'b0;
      endcase
   end

   // Datapath helpers for the current byte.
   always_comb begin
      xfer_s      = rx_valid && rx_ready;
      len_d       = {len_q[15:8], rx_data};
      word_d      = {asm_q, rx_data};
      acc_d       = csum_update(acc_q, rx_data);
      last_word_s = (word_cnt_q == (len_q - 16'd1));
   end

   // Loader FSM with all outputs registered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= HDR_HI;
         len_q       <= 16'd0;
         byte_cnt_q  <= 2'd0;
         word_cnt_q  <= 16'd0;
         acc_q       <= 8'd0;
         asm_q       <= 24'd0;
         waddr_q     <= '0;
         wdata_q     <= 32'd0;
         wena_q      <= 1'b0;
         cpu_reset_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         wena_q <= 1'b0;
         case (state_q)
            HDR_HI: begin
               if (xfer_s) begin
                  len_q[15:8] <= rx_data;
                  state_q     <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (xfer_s) begin
                  len_q <= len_d;
                  if ({1'b0, len_d} > MAX_WORDS) begin
                     state_q <= ERROR;
                     error_q <= 1'b1;
                  end else if (len_d == 16'd0) begin
                     state_q <= CSUM;
                  end else begin
                     state_q <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (xfer_s) begin
                  acc_q      <= acc_d;
                  asm_q      <= {asm_q[15:0], rx_data};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  // Fourth byte: the write strobe issues next cycle, overlapping the next byte.
                  if (byte_cnt_q == 2'd3) begin
                     wena_q     <= 1'b1;
                     wdata_q    <= word_d;
                     waddr_q    <= word_cnt_q[ADDR_WIDTH-1:0];
                     word_cnt_q <= word_cnt_q + 16'd1;
                     if (last_word_s) begin
                        state_q <= CSUM;
                     end
                  end
               end
            end
            CSUM: begin
               if (xfer_s) begin
                  if (rx_data == acc_q) begin
                     state_q     <= RUN;
                     cpu_reset_q <= 1'b1;
                     done_q      <= 1'b1;
                  end else begin
                     state_q <= ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (restart) begin
                  state_q     <= HDR_HI;
                  cpu_reset_q <= 1'b0;
                  done_q      <= 1'b0;
                  len_q       <= 16'd0;
                  byte_cnt_q  <= 2'd0;
                  word_cnt_q  <= 16'd0;
                  acc_q       <= 8'd0;
                  asm_q       <= 24'd0;
               end
            end
            ERROR: begin
               if (restart) begin
                  state_q     <= HDR_HI;
                  error_q     <= 1'b0;
                  len_q       <= 16'd0;
                  byte_cnt_q  <= 2'd0;
                  word_cnt_q  <= 16'd0;
                  acc_q       <= 8'd0;
                  asm_q       <= 24'd0;
               end
            end
            default: begin
               state_q     <= HDR_HI;
               cpu_reset_q <= 1'b0;
               done_q      <= 1'b0;
               error_q     <= 1'b0;
            end
         endcase
      end
   end

   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign imem_wena  = wena_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good/bad images, empty and oversize headers,
// stalled payload, async abort and restart from RUN.
module tb_boot_loader;

   localparam int AW = 10;

   typedef logic [7:0] byte_q_t[$];

   logic          clock;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          restart;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          imem_wena;
   logic          cpu_reset;
   logic          done;
   logic          error;

   int            vec_cnt;
   int            err_cnt;
   int            wide_cnt;
   logic          prev_wena;
   logic [AW-1:0] wq_addr[$];
   logic [31:0]   wq_data[$];

   // Good two-word image; checksum 3C^01^12^34^00^00^00^01 = 1A.
   logic [AW-1:0] exp_addr[2] = '{10'd0, 10'd1};
   logic [31:0]   exp_data[2] = '{32'h3C01_1234, 32'h0000_0001};

   boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .restart    (restart),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .imem_wena  (imem_wena),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Records every write strobe and flags strobes wider than one cycle.
   always @(negedge clock) begin
      if (imem_wena) begin
         wq_addr.push_back(imem_waddr);
         wq_data.push_back(imem_wdata);
         if (prev_wena) wide_cnt <= wide_cnt + 1;
      end
      prev_wena <= imem_wena;
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!rx_ready) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL send_byte_timeout: byte %02h rx_ready=%0b required 1", b, rx_ready);
      end else begin
         @(negedge clock);
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_bytes(input byte_q_t q, input bit gaps);
      foreach (q[i]) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            @(negedge clock);
         end
         send_byte(q[i]);
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      vec_cnt++;
      if ({cpu_reset, done, error, imem_wena, rx_ready} !== 5'b00001) begin
         err_cnt++;
         $display("FAIL reset_flags: got %05b required 00001", {cpu_reset, done, error, imem_wena, rx_ready});
      end
      vec_cnt++;
      if ({imem_waddr, imem_wdata} !== {10'd0, 32'd0}) begin
         err_cnt++;
         $display("FAIL reset_mem_port: got %0d/%08h required 0/00000000", imem_waddr, imem_wdata);
      end
   endtask

   task automatic test_good_image(input bit gaps);
      wq_addr.delete();
      wq_data.delete();
      wide_cnt = 0;
      if (gaps) restart = 1'b1;
      send_bytes('{8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01}, gaps);
      restart = 1'b0;
      vec_cnt++;
      if (cpu_reset !== 1'b0) begin
         err_cnt++;
         $display("FAIL pre_csum_cpu_reset: got %0b required 0", cpu_reset);
      end
      send_byte(8'h1A);
      rx_data  = 8'hFF;
      rx_valid = 1'b1;
      repeat (3) @(negedge clock);
      rx_valid = 1'b0;
      vec_cnt++;
      if ({cpu_reset, done, error, rx_ready} !== 4'b1100) begin
         err_cnt++;
         $display("FAIL run_flags(gaps=%0b): got %04b required 1100", gaps, {cpu_reset, done, error, rx_ready});
      end
      vec_cnt++;
      if (wq_addr.size() !== 2 || wide_cnt !== 0) begin
         err_cnt++;
         $display("FAIL write_count(gaps=%0b): got %0d writes, %0d wide required 2, 0", gaps, wq_addr.size(), wide_cnt);
      end else begin
         for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
               err_cnt++;
               $display("FAIL write_%0d(gaps=%0b): got %0d/%08h required %0d/%08h", i, gaps,
                        wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   task automatic test_restart_from_run();
      pulse_restart();
      vec_cnt++;
      if ({cpu_reset, done, rx_ready} !== 3'b001) begin
         err_cnt++;
         $display("FAIL restart_run: got %03b required 001", {cpu_reset, done, rx_ready});
      end
   endtask

   task automatic test_empty_image();
      wq_addr.delete();
      send_bytes('{8'h00, 8'h00, 8'h00}, 1'b0);
      vec_cnt++;
      if ({done, cpu_reset, error} !== 3'b110 || wq_addr.size() !== 0) begin
         err_cnt++;
         $display("FAIL empty_ok: got flags %03b writes %0d required 110, 0", {done, cpu_reset, error}, wq_addr.size());
      end
      pulse_restart();
      send_bytes('{8'h00, 8'h00, 8'h5A}, 1'b0);
      vec_cnt++;
      if ({done, cpu_reset, error} !== 3'b001 || wq_addr.size() !== 0) begin
         err_cnt++;
         $display("FAIL empty_bad_csum: got flags %03b writes %0d required 001, 0", {done, cpu_reset, error}, wq_addr.size());
      end
      pulse_restart();
      vec_cnt++;
      if ({error, rx_ready} !== 2'b01) begin
         err_cnt++;
         $display("FAIL restart_error: got %02b required 01", {error, rx_ready});
      end
   endtask

   task automatic test_bad_csum();
      wq_addr.delete();
      send_bytes('{8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 1'b0);
      rx_valid = 1'b1;
      repeat (3) @(negedge clock);
      rx_valid = 1'b0;
      vec_cnt++;
      if ({error, cpu_reset, done, rx_ready} !== 4'b1000 || wq_addr.size() !== 2) begin
         err_cnt++;
         $display("FAIL bad_csum: got flags %04b writes %0d required 1000, 2",
                  {error, cpu_reset, done, rx_ready}, wq_addr.size());
      end
      pulse_restart();
   endtask

   task automatic test_oversize();
      wq_addr.delete();
      send_bytes('{8'h04, 8'h01}, 1'b0);
      vec_cnt++;
      if ({error, rx_ready} !== 2'b10 || wq_addr.size() !== 0) begin
         err_cnt++;
         $display("FAIL oversize: got flags %02b writes %0d required 10, 0", {error, rx_ready}, wq_addr.size());
      end
      pulse_restart();
   endtask

   task automatic test_async_abort();
      send_bytes('{8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00}, 1'b0);
      #2 reset = 1'b0;
      #1;
      vec_cnt++;
      if ({cpu_reset, done, error, imem_wena, rx_ready} !== 5'b00001 || imem_wdata !== 32'd0 || imem_waddr !== 10'd0) begin
         err_cnt++;
         $display("FAIL async_abort: got flags %05b port %0d/%08h required 00001, 0/00000000",
                  {cpu_reset, done, error, imem_wena, rx_ready}, imem_waddr, imem_wdata);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      wide_cnt  = 0;
      prev_wena = 1'b0;
      reset     = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      restart   = 1'b0;
      test_reset();
      test_good_image(1'b0);
      test_restart_from_run();
      test_empty_image();
      test_bad_csum();
      test_oversize();
      test_good_image(1'b1);
      pulse_restart();
      test_async_abort();
      test_good_image(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
